// File: rtl/sgf_division_seq.sv
// ---------------------------------------------------------------------------
// sgf_division_seq
//
// Sequential restoring significand divider for the FPU divide path. It is the
// counterpart of the significand multiplier: given two unsigned SW-bit
// significands A and B it produces Q = floor(A * 2^SW / B) as an SW+1 bit
// quotient, one quotient bit per clock, MSB first. It also produces the final
// remainder, a sticky bit for rounding, and divide-by-zero / overflow flags.
//
// Ports
//   clk              system clock, all state changes on the rising edge
//   rst              synchronous active-high reset
//   start_i          request a division, accepted only while ready_o is high
//   Data_A_i         dividend significand (SW bits), sampled on accept
//   Data_B_i         divisor significand (SW bits), sampled on accept
//   ready_o          high in IDLE, a new division can be accepted
//   done_o           one-cycle pulse, the result outputs are valid
//   sgf_quotient_o   floor(A * 2^SW / B), SW+1 bits
//   sgf_remainder_o  final partial remainder, always smaller than B
//   sticky_o         remainder is non-zero
//   div_zero_o       divisor was zero
//   overflow_o       A >= 2*B, the quotient would not fit in SW+1 bits
//
// Timing
//   Normal division: accept edge, SW+1 CALC cycles, then one DONE cycle.
//   Zero divisor or overflow: accept edge goes straight to DONE.
//   Results are registered and held until the next accepted start.
// ---------------------------------------------------------------------------
module sgf_division_seq #(
  parameter int SW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [SW-1:0] Data_A_i,
  input  logic [SW-1:0] Data_B_i,
  output logic          ready_o,
  output logic          done_o,
  output logic [SW:0]   sgf_quotient_o,
  output logic [SW-1:0] sgf_remainder_o,
  output logic          sticky_o,
  output logic          div_zero_o,
  output logic          overflow_o
);

  // Counter must hold the value SW, since bits are produced for SW down to 0.
  localparam int CW = $clog2(SW + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(SW);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Control state
  logic [1:0]    state_q,     state_d;
  logic [CW-1:0] cnt_q,       cnt_d;

  // Working registers of the restoring iteration
  logic [SW:0]   rem_q,       rem_d;
  logic [SW:0]   quo_q,       quo_d;
  logic [SW-1:0] divisor_q,   divisor_d;

  // Result registers, held between divisions
  logic [SW:0]   quotOut_q,   quotOut_d;
  logic [SW-1:0] remOut_q,    remOut_d;
  logic          sticky_q,    sticky_d;
  logic          divZero_q,   divZero_d;
  logic          overflow_q,  overflow_d;

  // Datapath signals
  logic [SW:0]   divisorExt;
  logic          remGeDiv;
  logic [SW:0]   remSub;
  logic [SW:0]   remStep;
  logic [SW:0]   quoStep;
  logic          inBZero;
  logic          inOverflow;

  // One restoring step: compare the partial remainder against the divisor at
  // SW+1 bits, subtract when it fits, and shift the resulting quotient bit in
  // at the LSB of the working quotient.
  always_comb begin
    divisorExt = {1'b0, divisor_q};
    remGeDiv   = (rem_q >= divisorExt);
    remSub     = rem_q - divisorExt;
    remStep    = remGeDiv ? remSub : rem_q;
    quoStep    = {quo_q[SW-1:0], remGeDiv};
  end

  // Input screening done on the accepting edge. The quotient only fits in
  // SW+1 bits when A < 2*B; {B,0} is exactly 2*B at SW+1 bits.
  always_comb begin
    inBZero    = (Data_B_i == '0);
    inOverflow = ({1'b0, Data_A_i} >= {Data_B_i, 1'b0});
  end

  // Next-state logic. An accepted start clears every result register; the
  // special cases load the saturated quotient and skip the iteration.
  // In CALC the remainder is shifted after each step except the last one:
  // after a step the remainder is below B, so the shift never loses its MSB.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    divisor_d  = divisor_q;
    quotOut_d  = quotOut_q;
    remOut_d   = remOut_q;
    sticky_d   = sticky_q;
    divZero_d  = divZero_q;
    overflow_d = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          divisor_d  = Data_B_i;
          quotOut_d  = '0;
          remOut_d   = '0;
          sticky_d   = 1'b0;
          divZero_d  = 1'b0;
          overflow_d = 1'b0;
          quo_d      = '0;
          if (inBZero) begin
            divZero_d = 1'b1;
            quotOut_d = '1;
            rem_d     = '0;
            cnt_d     = '0;
            state_d   = ST_DONE;
          end else if (inOverflow) begin
            overflow_d = 1'b1;
            quotOut_d  = '1;
            rem_d      = '0;
            cnt_d      = '0;
            state_d    = ST_DONE;
          end else begin
            rem_d   = {1'b0, Data_A_i};
            cnt_d   = CNT_INIT;
            state_d = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        quo_d = quoStep;
        if (cnt_q != '0) begin
          rem_d = {remStep[SW-1:0], 1'b0};
          cnt_d = cnt_q - CW'(1);
        end else begin
          rem_d     = remStep;
          quotOut_d = quoStep;
          remOut_d  = remStep[SW-1:0];
          sticky_d  = |remStep[SW-1:0];
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and data registers. Reset aborts any division in flight and clears
  // every register, so no done pulse follows a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      divisor_q  <= '0;
      quotOut_q  <= '0;
      remOut_q   <= '0;
      sticky_q   <= 1'b0;
      divZero_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      divisor_q  <= divisor_d;
      quotOut_q  <= quotOut_d;
      remOut_q   <= remOut_d;
      sticky_q   <= sticky_d;
      divZero_q  <= divZero_d;
      overflow_q <= overflow_d;
    end
  end

  // Outputs come straight from registers; there is no input-to-output path.
  always_comb begin
    ready_o         = (state_q == ST_IDLE);
    done_o          = (state_q == ST_DONE);
    sgf_quotient_o  = quotOut_q;
    sgf_remainder_o = remOut_q;
    sticky_o        = sticky_q;
    div_zero_o      = divZero_q;
    overflow_o      = overflow_q;
  end

endmodule

// File: tb/tb_sgf_division_seq.sv
// ---------------------------------------------------------------------------
// tb_sgf_division_seq
//
// Self-checking bench for sgf_division_seq. Two instances are used: a 4-bit
// one driven with hand-computed vectors and a 24-bit one driven with
// normalized random operands whose expected quotient and remainder are
// computed with wide integer arithmetic. Expected results are queued when a
// division is issued and popped by a monitor on every done pulse.
// ---------------------------------------------------------------------------
module tb_sgf_division_seq;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        st;
    logic        dz;
    logic        ov;
    int          lat;
    int          acc;
  } exp_t;

  logic clk;
  int   cyc;
  int   checkCount;
  int   passCount;

  // 4-bit instance signals
  logic        rst4, start4, ready4, done4, st4, dz4, ov4;
  logic [3:0]  dataA4, dataB4, r4;
  logic [4:0]  q4;

  // 24-bit instance signals
  logic        rst24, start24, ready24, done24, st24, dz24, ov24;
  logic [23:0] dataA24, dataB24, r24;
  logic [24:0] q24;

  exp_t exp4[$];
  exp_t exp24[$];

  sgf_division_seq #(.SW(4)) dut4 (
    .clk             (clk),
    .rst             (rst4),
    .start_i         (start4),
    .Data_A_i        (dataA4),
    .Data_B_i        (dataB4),
    .ready_o         (ready4),
    .done_o          (done4),
    .sgf_quotient_o  (q4),
    .sgf_remainder_o (r4),
    .sticky_o        (st4),
    .div_zero_o      (dz4),
    .overflow_o      (ov4)
  );

  sgf_division_seq #(.SW(24)) dut24 (
    .clk             (clk),
    .rst             (rst24),
    .start_i         (start24),
    .Data_A_i        (dataA24),
    .Data_B_i        (dataB24),
    .ready_o         (ready24),
    .done_o          (done24),
    .sgf_quotient_o  (q24),
    .sgf_remainder_o (r24),
    .sticky_o        (st24),
    .div_zero_o      (dz24),
    .overflow_o      (ov24)
  );

  // Free-running clock and an edge counter used to measure latency.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point: every check goes through here and steps the counts.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checkCount++;
    if (act === req) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic exp_t mkExp(input logic [63:0] q, input logic [63:0] r,
                                 input logic st, input logic dz, input logic ov, input int lat);
    exp_t e;
    e.q = q; e.r = r; e.st = st; e.dz = dz; e.ov = ov; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  // Issue a division on the 4-bit instance at a falling edge so it is taken on
  // the next rising edge; the operands are scrambled afterwards to show they
  // were latched.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input exp_t e, input bit push);
    int k;
    k = 0;
    while (!ready4 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!ready4) checkOutput("ready4 timeout", {63'd0, ready4}, 64'd1);
    dataA4 = a;
    dataB4 = b;
    start4 = 1'b1;
    e.acc  = cyc;
    if (push) exp4.push_back(e);
    @(negedge clk);
    start4 = 1'b0;
    dataA4 = ~a;
    dataB4 = 4'b0000;
  endtask

  task automatic applyStimulus24(input logic [23:0] a, input logic [23:0] b, input exp_t e);
    int k;
    k = 0;
    while (!ready24 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!ready24) checkOutput("ready24 timeout", {63'd0, ready24}, 64'd1);
    dataA24 = a;
    dataB24 = b;
    start24 = 1'b1;
    e.acc   = cyc;
    exp24.push_back(e);
    @(negedge clk);
    start24 = 1'b0;
    dataA24 = '0;
    dataB24 = '0;
  endtask

  // Bounded waits for the done pulse; they return at the falling edge inside
  // the DONE cycle.
  task automatic waitDone4();
    int k;
    k = 0;
    while (!done4 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!done4) checkOutput("done4 timeout", {63'd0, done4}, 64'd1);
  endtask

  task automatic waitDone24();
    int k;
    k = 0;
    while (!done24 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!done24) checkOutput("done24 timeout", {63'd0, done24}, 64'd1);
  endtask

  // Monitor for the 4-bit instance: every done pulse must match the oldest
  // queued expectation, and a pulse with nothing queued is an error.
  always @(negedge clk) begin
    exp_t e;
    if (!rst4 && done4) begin
      if (exp4.size() == 0) begin
        checkOutput("done4 unexpected", 64'd1, 64'd0);
      end else begin
        e = exp4.pop_front();
        checkOutput("q4 quotient",  {59'd0, q4}, e.q);
        checkOutput("q4 remainder", {60'd0, r4}, e.r);
        checkOutput("q4 sticky",    {63'd0, st4}, {63'd0, e.st});
        checkOutput("q4 div_zero",  {63'd0, dz4}, {63'd0, e.dz});
        checkOutput("q4 overflow",  {63'd0, ov4}, {63'd0, e.ov});
        checkOutput("q4 latency",   64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end

  // Monitor for the 24-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst24 && done24) begin
      if (exp24.size() == 0) begin
        checkOutput("done24 unexpected", 64'd1, 64'd0);
      end else begin
        e = exp24.pop_front();
        checkOutput("q24 quotient",  {39'd0, q24}, e.q);
        checkOutput("q24 remainder", {40'd0, r24}, e.r);
        checkOutput("q24 sticky",    {63'd0, st24}, {63'd0, e.st});
        checkOutput("q24 flags",     {62'd0, dz24, ov24}, 64'd0);
        checkOutput("q24 latency",   64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end

  // Main sequence: reset, directed 4-bit vectors, abort cases, then random
  // normalized 24-bit divisions back to back.
  initial begin
    exp_t dummy;
    logic [31:0] rndA, rndB;
    logic [23:0] a, b;
    logic [47:0] num, qq, rr;

    checkCount = 0;
    passCount  = 0;
    rst4 = 1'b1; rst24 = 1'b1;
    start4 = 1'b0; start24 = 1'b0;
    dataA4 = '0; dataB4 = '0; dataA24 = '0; dataB24 = '0;
    dummy = mkExp(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst4 = 1'b0; rst24 = 1'b0;

    checkOutput("reset ready4",   {63'd0, ready4}, 64'd1);
    checkOutput("reset done4",    {63'd0, done4}, 64'd0);
    checkOutput("reset quot4",    {59'd0, q4}, 64'd0);
    checkOutput("reset rem4",     {60'd0, r4}, 64'd0);
    checkOutput("reset flags4",   {61'd0, st4, dz4, ov4}, 64'd0);
    checkOutput("reset ready24",  {63'd0, ready24}, 64'd1);

    applyStimulus(4'b1111, 4'b1000, mkExp(5'b11110, 4'b0000, 0, 0, 0, 6), 1); waitDone4();
    applyStimulus(4'b1000, 4'b1111, mkExp(5'b01000, 4'b1000, 1, 0, 0, 6), 1); waitDone4();
    applyStimulus(4'b1100, 4'b1100, mkExp(5'b10000, 4'b0000, 0, 0, 0, 6), 1); waitDone4();
    @(negedge clk);
    checkOutput("held quot4",  {59'd0, q4}, 64'b10000);
    checkOutput("held ready4", {63'd0, ready4}, 64'd1);
    applyStimulus(4'b1010, 4'b1100, mkExp(5'b01101, 4'b0100, 1, 0, 0, 6), 1); waitDone4();
    applyStimulus(4'b1011, 4'b0000, mkExp(5'b11111, 4'b0000, 0, 1, 0, 1), 1); waitDone4();
    applyStimulus(4'b1111, 4'b0111, mkExp(5'b11111, 4'b0000, 0, 0, 1, 1), 1); waitDone4();
    applyStimulus(4'b0001, 4'b1111, mkExp(5'b00001, 4'b0001, 1, 0, 0, 6), 1); waitDone4();
    applyStimulus(4'b0000, 4'b0101, mkExp(5'b00000, 4'b0000, 0, 0, 0, 6), 1); waitDone4();

    // A start pulse during CALC must be ignored.
    applyStimulus(4'b1111, 4'b1000, mkExp(5'b11110, 4'b0000, 0, 0, 0, 6), 1);
    @(negedge clk);
    dataA4 = 4'b0001; dataB4 = 4'b0001; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    waitDone4();
    repeat (8) @(negedge clk);

    // Reset in CALC aborts the division with no done pulse.
    applyStimulus(4'b1111, 4'b1000, dummy, 0);
    @(negedge clk);
    @(negedge clk);
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    checkOutput("abort ready4", {63'd0, ready4}, 64'd1);
    checkOutput("abort done4",  {63'd0, done4}, 64'd0);
    checkOutput("abort quot4",  {59'd0, q4}, 64'd0);
    checkOutput("abort flags4", {61'd0, st4, dz4, ov4}, 64'd0);
    repeat (12) @(negedge clk);
    checkOutput("abort idle4",  {63'd0, ready4}, 64'd1);

    for (int i = 0; i < 1000; i++) begin
      rndA = $urandom();
      rndB = $urandom();
      a = {1'b1, rndA[22:0]};
      b = {1'b1, rndB[22:0]};
      num = {a, 24'd0};
      qq  = num / {24'd0, b};
      rr  = num % {24'd0, b};
      applyStimulus24(a, b, mkExp({16'd0, qq}, {16'd0, rr}, (rr != 48'd0), 0, 0, 26));
      waitDone24();
    end

    repeat (5) @(negedge clk);
    checkOutput("queue4 drained",  64'(exp4.size()), 64'd0);
    checkOutput("queue24 drained", 64'(exp24.size()), 64'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/sgf_division_seq.md
Name: sgf_division_seq

Overview:
- Sequential restoring significand divider; the inverse operation of the team's significand multiplier, for the FPU divide path.
- Accepts two unsigned SW-bit significands and produces Q = floor(A·2^SW / B) as an SW+1-bit quotient, one bit per cycle.
- Also produces the remainder, a sticky bit for rounding, and divide-by-zero and overflow flags.
- Handshake is start/ready/done; results are held until the next accepted start.

Parameters:
- SW, 24, significand width in bits of Data_A_i and Data_B_i.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  request a division; accepted only when ready_o=1.
- Data_A_i  in  SW  dividend significand; sampled on the accepting edge.
- Data_B_i  in  SW  divisor significand; sampled on the accepting edge.
- ready_o  out  1  high in IDLE; a division can be accepted.
- done_o  out  1  one-cycle pulse; results are valid.
- sgf_quotient_o  out  SW+1  floor(A·2^SW/B).
- sgf_remainder_o  out  SW  final partial remainder; always < B.
- sticky_o  out  1  1 when sgf_remainder_o != 0.
- div_zero_o  out  1  B was 0.
- overflow_o  out  1  A >= 2·B; the quotient would need more than SW+1 bits.

Behaviour:
- Reset (rst=1 on an edge): FSM goes to IDLE; ready_o=1; all other outputs and internal registers = 0. Reset mid-operation aborts the division; no done_o is produced.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - ready_o=1. start_i=1 latches A and B.
  - If B==0: next state DONE with div_zero_o=1, quotient all ones, remainder 0, sticky 0, overflow 0.
  - Else if A >= 2·B (compared at SW+1 bits): next state DONE with overflow_o=1, quotient all ones, remainder 0, sticky 0.
  - Otherwise: R := {0,A} (SW+1 bits), Q := 0, counter := SW, clear all flags; next state CALC.
- CALC: one quotient bit per cycle, MSB first, for counter = SW down to 0.
  - If R >= {0,B}: q = 1 and R := R − B; else q = 0.
  - Q := {Q[SW-1:0], q}.
  - If counter != 0: R := R << 1 (fits in SW+1 bits because R < B after the step), and decrement counter.
  - When counter == 0: next state DONE; sgf_remainder_o := R[SW-1:0].
  - ready_o=0; start_i is ignored.
- DONE: done_o=1 for exactly this cycle; ready_o=0; next state IDLE.
- Latency:
  - Normal division: start accepted on edge t, CALC occupies SW+1 cycles, done_o is high during cycle t+SW+2.
  - Zero divisor or overflow: done_o is high during cycle t+1.
- Output hold:
  - sgf_quotient_o, sgf_remainder_o, sticky_o, div_zero_o and overflow_o are registered.
  - They are valid from the DONE cycle and held unchanged until the next accepted start, which clears them.
- Back-to-back: start_i may be asserted in the cycle after DONE (IDLE). There is no accept during DONE itself; throughput is one division per SW+3 cycles.
- Input changes on Data_A_i/Data_B_i after acceptance have no effect.
- Normalized inputs (MSB=1 on both) never overflow; the quotient then lies in [2^(SW-1), 2^(SW+1)).
- Arithmetic: the comparator and subtractor are SW+1 bits wide. No combinational path from inputs to outputs.

Test Plan:
- SW=4; A=1111, B=1000; start 1 cycle -> done_o exactly 6 cycles after accept; quotient=11110, remainder=0000, sticky=0, flags 0.
- SW=4; A=1000, B=1111 -> quotient=01000, remainder=1000, sticky=1.
- SW=4; A=1100, B=1100 -> quotient=10000, remainder=0, sticky=0. Then immediate second start the cycle after DONE with A=1010, B=1100 -> quotient=01101, remainder=0100, sticky=1. Previous result held until that start.
- SW=4; B=0000, A=1011 -> done_o 1 cycle after accept; div_zero_o=1, quotient=11111, overflow_o=0. Then A=1111, B=0111 -> overflow_o=1, quotient=11111, div_zero_o=0.
- SW=4; start A=1111, B=1000; pulse start_i again at CALC cycle 2 -> ignored, single done_o, quotient=11110. Then start, assert rst at CALC cycle 3 -> no done_o; ready_o=1 and all outputs 0 next cycle.
- SW=24 random normalized pairs (≥1000) -> quotient·B + remainder == A·2^24 and remainder < B; done_o latency = 26 cycles every time.
